// File: rtl/instr_cache_ctrl.sv
// Direct-mapped instruction cache controller: single outstanding fetch,
// one-line refill from memory with critical-word forwarding.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no fetch in flight, ready to accept
// S_LOOKUP   | tag compare for the captured address, hit returns a word
// S_MEM_WAIT | refill requested, waiting for i_mem_read_done
module instr_cache_ctrl #(
    parameter int ADDR_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int INDEX_BITS       = 6,
    parameter int INSTR_WIDTH      = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]       i_fetch_addr,
    input  logic                        i_fetch_kill,
    input  logic                        i_flush,
    output logic                        o_ready,
    output logic                        o_instr_valid,
    output logic [INSTR_WIDTH-1:0]      o_instr,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    output logic                        o_mem_read_req,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - 5 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_WAIT} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:2]       addr_q;
    logic [INDEX_BITS-1:0]       idx;
    logic [TAG_W-1:0]            tag;
    logic [2:0]                  wsel;
    logic [LINES-1:0]            valid_q;
    logic [TAG_W-1:0]            tag_mem  [LINES];
    logic [CACHE_LINE_WIDTH-1:0] data_mem [LINES];
    logic [CACHE_LINE_WIDTH-1:0] hit_line;
    logic [INSTR_WIDTH-1:0]      hit_word;
    logic [INSTR_WIDTH-1:0]      fill_word;
    logic [INSTR_WIDTH-1:0]      instr_q;
    logic                        hit;
    logic                        accept;
    logic                        lookup_ok;
    logic                        refill_done;
    logic                        kill_pend_q;
    logic                        flush_pend_q;
    logic                        unused_addr_lsbs;

    assign unused_addr_lsbs = ^i_fetch_addr[1:0];

    assign idx       = addr_q[4+INDEX_BITS:5];
    assign tag       = addr_q[ADDR_WIDTH-1:5+INDEX_BITS];
    assign wsel      = addr_q[4:2];
    assign hit_line  = data_mem[idx];
    assign hit_word  = hit_line[wsel*INSTR_WIDTH +: INSTR_WIDTH];
    assign fill_word = i_cache_line[wsel*INSTR_WIDTH +: INSTR_WIDTH];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);

    assign lookup_ok   = (state_q == S_LOOKUP) && hit && !i_fetch_kill;
    assign refill_done = (state_q == S_MEM_WAIT) && i_mem_read_done;
    assign accept      = i_fetch_req && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (i_fetch_kill) state_d = S_IDLE;
                else if (hit)     state_d = accept ? S_LOOKUP : S_IDLE;
                else              state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: if (i_mem_read_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready       = (state_q == S_IDLE) || lookup_ok;
        o_instr_valid = lookup_ok
                     || (refill_done && !(kill_pend_q || i_fetch_kill));
        o_instr       = instr_q;
        if (lookup_ok)          o_instr = hit_word;
        else if (o_instr_valid) o_instr = fill_word;
    end

    // The request address is never reset; it is only consumed after an accept.
    always_ff @(posedge i_clk) begin
        if (accept) addr_q <= i_fetch_addr[ADDR_WIDTH-1:2];
    end

    // Kill and flush seen while waiting are remembered until the refill lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_read_req     <= 1'b0;
            o_mem_read_address <= '0;
            instr_q            <= '0;
            valid_q            <= '0;
            kill_pend_q        <= 1'b0;
            flush_pend_q       <= 1'b0;
        end else begin
            o_mem_read_req <= (state_q == S_LOOKUP) && !hit && !i_fetch_kill;
            if ((state_q == S_LOOKUP) && !hit && !i_fetch_kill)
                o_mem_read_address <= {addr_q[ADDR_WIDTH-1:5], 5'b0};
            if (o_instr_valid) instr_q <= o_instr;
            if (state_q == S_MEM_WAIT) begin
                kill_pend_q  <= (kill_pend_q  || i_fetch_kill) && !i_mem_read_done;
                flush_pend_q <= (flush_pend_q || i_flush)      && !i_mem_read_done;
            end else begin
                kill_pend_q  <= 1'b0;
                flush_pend_q <= 1'b0;
            end
            if (i_flush)                          valid_q      <= '0;
            else if (refill_done && !flush_pend_q) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (refill_done && !i_rst) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= i_cache_line;
        end
    end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed bench for instr_cache_ctrl: cold miss, hits, conflict, kill,
// flush and reset-during-refill scenarios with hand-computed words.
module tb_instr_cache_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_fetch_req;
    logic [63:0]  i_fetch_addr;
    logic         i_fetch_kill;
    logic         i_flush;
    logic         o_ready;
    logic         o_instr_valid;
    logic [31:0]  o_instr;
    logic [63:0]  o_mem_read_address;
    logic         o_mem_read_req;
    logic         i_mem_read_done;
    logic [255:0] i_cache_line;

    int n_total = 0;
    int n_bad   = 0;

    instr_cache_ctrl dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_fetch_req        (i_fetch_req),
        .i_fetch_addr       (i_fetch_addr),
        .i_fetch_kill       (i_fetch_kill),
        .i_flush            (i_flush),
        .o_ready            (o_ready),
        .o_instr_valid      (o_instr_valid),
        .o_instr            (o_instr),
        .o_mem_read_address (o_mem_read_address),
        .o_mem_read_req     (o_mem_read_req),
        .i_mem_read_done    (i_mem_read_done),
        .i_cache_line       (i_cache_line)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Word k of a line based at 'base' is {base[15:0], k}.
    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = {base[15:0], 16'(k)};
        return l;
    endfunction

    task automatic fetch_start(input logic [63:0] a);
        i_fetch_req  = 1'b1;
        i_fetch_addr = a;
        #2;
        chk("accept_ready", o_ready, 1);
        cyc();
        i_fetch_req = 1'b0;
    endtask

    task automatic expect_hit(input logic [31:0] w);
        #2;
        chk("hit_valid", o_instr_valid, 1);
        chk("hit_word", o_instr, w);
        cyc();
        #2;
        chk("hit_no_refill", o_mem_read_req, 0);
        chk("hit_idle_valid", o_instr_valid, 0);
    endtask

    task automatic expect_miss(input logic [63:0] ra, input logic [255:0] line,
                               input logic [31:0] w, input logic kill_mw, input logic flush_mw);
        #2;
        chk("miss_no_valid", o_instr_valid, 0);
        chk("miss_not_ready", o_ready, 0);
        cyc();
        i_fetch_kill = kill_mw;
        i_flush      = flush_mw;
        #2;
        chk("refill_req", o_mem_read_req, 1);
        chk("refill_addr", o_mem_read_address, ra);
        chk("wait_no_valid", o_instr_valid, 0);
        cyc();
        i_fetch_kill    = 1'b0;
        i_flush         = 1'b0;
        i_mem_read_done = 1'b1;
        i_cache_line    = line;
        #2;
        chk("fill_valid", o_instr_valid, !kill_mw);
        if (!kill_mw) chk("fill_word", o_instr, w);
        chk("refill_req_one_cycle", o_mem_read_req, 0);
        chk("refill_addr_held", o_mem_read_address, ra);
        cyc();
        i_mem_read_done = 1'b0;
        i_cache_line    = '0;
        #2;
        chk("back_to_idle", o_ready, 1);
        chk("post_fill_valid", o_instr_valid, 0);
    endtask

    logic [255:0] l1000, l1800, l2000, l3000;

    initial begin
        i_rst = 1'b1; i_fetch_req = 1'b0; i_fetch_addr = '0; i_fetch_kill = 1'b0;
        i_flush = 1'b0; i_mem_read_done = 1'b0; i_cache_line = '0;
        l1000 = mk_line(32'h1000);
        l1000[63:32] = 32'h00A00093;
        l1800 = mk_line(32'h1800);
        l2000 = mk_line(32'h2000);
        l3000 = mk_line(32'h3000);
        cyc(); cyc();
        i_rst = 1'b0;
        #2;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_req", o_mem_read_req, 0);
        chk("rst_addr", o_mem_read_address, 0);
        cyc();

        // cold miss, critical word forwarded
        fetch_start(64'h1004);
        expect_miss(64'h1000, l1000, 32'h00A00093, 1'b0, 1'b0);
        chk("instr_held_idle", o_instr, 32'h00A00093);
        cyc();

        fetch_start(64'h101C);
        expect_hit(32'h1000_0007);
        cyc();

        // back-to-back hits while staying in lookup
        fetch_start(64'h1008);
        i_fetch_req  = 1'b1;
        i_fetch_addr = 64'h1010;
        #2;
        chk("b2b_valid", o_instr_valid, 1);
        chk("b2b_word", o_instr, 32'h1000_0002);
        chk("b2b_ready", o_ready, 1);
        cyc();
        i_fetch_req = 1'b0;
        expect_hit(32'h1000_0004);
        cyc();

        // conflict eviction on index 0
        fetch_start(64'h1800);
        expect_miss(64'h1800, l1800, 32'h1800_0000, 1'b0, 1'b0);
        cyc();
        fetch_start(64'h1000);
        expect_miss(64'h1000, l1000, 32'h1000_0000, 1'b0, 1'b0);
        cyc();

        // kill in lookup: no response, no refill
        fetch_start(64'h1800);
        i_fetch_kill = 1'b1;
        #2;
        chk("kill_lookup_valid", o_instr_valid, 0);
        chk("kill_lookup_ready", o_ready, 0);
        cyc();
        i_fetch_kill = 1'b0;
        #2;
        chk("kill_lookup_no_req", o_mem_read_req, 0);
        chk("kill_lookup_idle", o_ready, 1);
        cyc();

        // kill during refill still writes the line
        fetch_start(64'h2000);
        expect_miss(64'h2000, l2000, 32'h2000_0000, 1'b1, 1'b0);
        chk("kill_instr_unchanged", o_instr, 32'h1000_0000);
        cyc();
        fetch_start(64'h2000);
        expect_hit(32'h2000_0000);
        cyc();

        // flush invalidates a resident line
        fetch_start(64'h2004);
        expect_hit(32'h2000_0001);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        fetch_start(64'h2004);
        expect_miss(64'h2000, l2000, 32'h2000_0001, 1'b0, 1'b0);
        cyc();

        // flush during refill: word returned, line left invalid
        fetch_start(64'h1000);
        expect_miss(64'h1000, l1000, 32'h1000_0000, 1'b0, 1'b1);
        cyc();
        fetch_start(64'h1000);
        expect_miss(64'h1000, l1000, 32'h1000_0000, 1'b0, 1'b0);
        cyc();

        // reset while waiting for a refill
        fetch_start(64'h3000);
        #2;
        chk("rm_miss", o_instr_valid, 0);
        cyc();
        i_rst = 1'b1;
        cyc();
        i_rst           = 1'b0;
        i_mem_read_done = 1'b1;
        i_cache_line    = l3000;
        #2;
        chk("rm_valid", o_instr_valid, 0);
        chk("rm_ready", o_ready, 1);
        chk("rm_req", o_mem_read_req, 0);
        chk("rm_addr", o_mem_read_address, 0);
        chk("rm_instr", o_instr, 0);
        cyc();
        i_mem_read_done = 1'b0;
        i_cache_line    = '0;
        fetch_start(64'h3000);
        expect_miss(64'h3000, l3000, 32'h3000_0000, 1'b0, 1'b0);
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
